fu_result_buffer: RTL and testbench
===================================

# fu_result_buffer

Per-functional-unit output queue that sits between an FU's result stage and the CDB arbiter. It captures completed FU_PACKETs and presents the oldest one to the CDB as a `fu_done` request with `wr_data`. It pops that entry only in a cycle where the arbiter does not return `stall_sig`, so FUs never lose a result when they lose arbitration. It also back-pressures the FU when the queue is full and discards all queued results on a flush.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of 2 and ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy counter.

Ports:
- `clock`  input  1: the block's single clock.
- `reset`  input  1: synchronous, active-high reset; clears all state at the `clock` edge.
- `in_valid`  input  1: the FU has a completed result this cycle.
- `in_packet`  input  FU_PACKET: result from the FU (`decoded_vals`, `result`).
- `in_ready`  output  1: the buffer can accept a push this cycle.
- `flush`  input  1: mispredict squash; discards all entries.
- `stall_sig`  input  1: this FU's `stall_sig` bit from the CDB arbiter (1 = not granted).
- `fu_done`  output  1: request to the CDB; the head entry is valid.
- `wr_data`  output  FU_PACKET: head entry; '0 when empty.
- `count`  output  CNT_W: current occupancy (0..DEPTH).

## Operation
- State:
  - circular array `buf[DEPTH]`;
  - `head` and `tail` pointers, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - `count` register.
- `fu_done = (count != 0)`; `wr_data = fu_done ? buf[head] : '0`.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `stall_sig`.
- Push: `push = in_valid && in_ready`. Writes `in_packet` to `buf[tail]` and advances `tail` (tail+1 mod DEPTH).
- Pop: `pop = fu_done && !stall_sig`. Advances `head`.
  - `stall_sig` is ignored while `fu_done` is 0.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- Full: `in_ready` is 0, so a push is impossible even if a pop occurs in the same cycle. `in_valid` while full is dropped, and it is the FU's responsibility to hold.
- Empty: no pop is possible, and `wr_data` is '0.
- Priority: `reset` > `flush` > push/pop.
  - `flush` sets `head`, `tail` and `count` to 0 at the edge.
  - A same-cycle push is discarded.
  - A same-cycle pop is irrelevant.
- Ordering: results leave strictly in push order (FIFO), including across pointer wrap.
- Entry contents are not cleared on pop or flush. Only `wr_data` masking guarantees '0 output.

## Timing
- Reset values:
  - `fu_done` = 0;
  - `wr_data` = '0;
  - `count` = 0;
  - `in_ready` = 1;
  - `head` = `tail` = 0.
- Push-to-request latency: a packet pushed at edge t is presented on `fu_done`/`wr_data` in the cycle after t. There is no same-cycle bypass.
- Grant handshake: the arbiter computes `stall_sig` combinationally from `fu_done` in the same cycle. On an ungranted cycle (`stall_sig`=1), `wr_data` holds the identical packet the following cycle.
- On a granted cycle, the next entry (if any) is presented in the following cycle. Back-to-back grants drain one entry per cycle.
- `in_ready` reflects occupancy at the start of the cycle. After a pop from full, `in_ready` returns to 1 one cycle later.
- `flush` or `reset` asserted mid-stream: in the next cycle, `fu_done` = 0 and `count` = 0.

## Test plan
- Reset, then a single push of P0 (`result`=32'h11) at cycle 1 with `stall_sig`=0 → `fu_done`=1 and `wr_data.result`=32'h11 in cycle 2; `fu_done`=0 and `count`=0 in cycle 3.
- Push P0, then hold `stall_sig`=1 for 3 cycles → `wr_data` stays P0 for all 3 cycles and `count` stays 1. `stall_sig`=0 in the 4th cycle → pop; `count`=0 in the next cycle.
- With DEPTH=4 and `stall_sig`=1, push 4 packets → `count`=4 and `in_ready`=0. A 5th `in_valid` is dropped. After release, exactly 4 pops occur in order 0,1,2,3.
- With `count`=2, assert push and pop in the same cycle → `count` stays 2, and the head advances to the second-oldest entry.
- Wrap-around: push and drain 6 packets with interleaved stalls so that `tail` wraps past 3 → output order equals input order with no duplicates.
- With `count`=3, assert `flush` together with `in_valid` → `count`=0, `fu_done`=0 and `in_ready`=1 in the next cycle. The flushed packet is never presented.

Source files
------------

// File: rtl/fu_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fu_result_buffer (with fu_result_buffer_pkg)                 |
// | Description : Per-FU result FIFO between the FU result stage and the CDB   |
// |               arbiter. Holds completed packets until they win arbitration, |
// |               back-pressures the FU when full, and drops all on flush.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package fu_result_buffer_pkg;
   // Completed FU result: decoded instruction fields plus the computed value.
   typedef struct packed {
      logic [31:0] decoded_vals;
      logic [31:0] result;
   } FU_PACKET;
endpackage

module fu_result_buffer
   import fu_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  FU_PACKET         in_packet,
   output logic             in_ready,
   input  logic             flush,
   input  logic             stall_sig,
   output logic             fu_done,
   output FU_PACKET         wr_data,
   output logic [CNT_W-1:0] count
);

   localparam int c_PTR_W = $clog2(DEPTH);

   FU_PACKET           r_buf [DEPTH];
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [CNT_W-1:0]   r_count;

   logic               w_push;
   logic               w_pop;

   // Handshake signals derive only from registered occupancy, so the
   // arbiter's stall_sig never loops back into in_ready or fu_done.
   always_comb begin
      fu_done  = (r_count != '0);
      in_ready = (r_count != CNT_W'(DEPTH));
      w_push   = in_valid && in_ready;
      w_pop    = fu_done && !stall_sig;
      wr_data  = fu_done ? r_buf[r_head] : '0;
      count    = r_count;
   end

   // Pointer and occupancy update; reset and flush both empty the queue,
   // and a push coinciding with a flush is discarded.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are left stale on pop/flush because the
   // output mask on wr_data hides anything outside the live window.
   always_ff @(posedge clock) begin
      if (w_push && !flush && !reset) begin
         r_buf[r_tail] <= in_packet;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fu_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fu_result_buffer                                          |
// | Description : Scoreboard bench for fu_result_buffer: expected packets are  |
// |               queued as they are pushed and compared when presented.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_fu_result_buffer;
   import fu_result_buffer_pkg::*;

   localparam int c_DEPTH = 4;
   localparam int c_CNT_W = $clog2(c_DEPTH + 1);

   logic               clock;
   logic               reset;
   logic               in_valid;
   FU_PACKET           in_packet;
   logic               in_ready;
   logic               flush;
   logic               stall_sig;
   logic               fu_done;
   FU_PACKET           wr_data;
   logic [c_CNT_W-1:0] count;

   FU_PACKET           sb_q [$];
   int                 n_checks;
   int                 n_pass;
   int                 n_pops;

   fu_result_buffer #(
      .DEPTH (c_DEPTH)
   ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_packet (in_packet),
      .in_ready  (in_ready),
      .flush     (flush),
      .stall_sig (stall_sig),
      .fu_done   (fu_done),
      .wr_data   (wr_data),
      .count     (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic FU_PACKET mk_pkt(input logic [31:0] res);
      FU_PACKET p;
      p.decoded_vals = res ^ 32'hA5A5_0000;
      p.result       = res;
      return p;
   endfunction

   // One clock cycle: drive inputs, check outputs against the scoreboard at
   // the falling edge, then apply the expected effect of the rising edge.
   task automatic cycle(input bit v, input logic [31:0] res, input bit st,
                        input bit fl, input bit rs);
      FU_PACKET p;
      bit       full;
      bit       pop;
      p         = mk_pkt(res);
      in_valid  = v;
      in_packet = p;
      stall_sig = st;
      flush     = fl;
      reset     = rs;
      @(negedge clock);
      check_eq("fu_done",  64'(fu_done),  64'(sb_q.size() != 0));
      check_eq("count",    64'(count),    64'(sb_q.size()));
      check_eq("in_ready", 64'(in_ready), 64'(sb_q.size() != c_DEPTH));
      if (sb_q.size() != 0) begin
         check_eq("wr_data", 64'(wr_data), 64'(sb_q[0]));
      end else begin
         check_eq("wr_data_empty", 64'(wr_data), 64'd0);
      end
      if (rs || fl) begin
         sb_q.delete();
      end else begin
         full = (sb_q.size() == c_DEPTH);
         pop  = (sb_q.size() != 0) && !st;
         if (pop) begin
            void'(sb_q.pop_front());
            n_pops++;
         end
         if (v && !full) begin
            sb_q.push_back(p);
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_pops    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_packet = '0;
      flush     = 1'b0;
      stall_sig = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state, then single push/present/pop.
      cycle(0, 32'h0, 0, 0, 0);
      cycle(1, 32'h11, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0);

      // Held under stall for 3 cycles, then granted.
      cycle(1, 32'h22, 1, 0, 0);
      repeat (3) cycle(0, 32'h0, 1, 0, 0);
      cycle(0, 32'h0, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0);

      // Fill to capacity; the fifth push is dropped; drain in order.
      for (int i = 0; i < 5; i++) cycle(1, 32'h30 + 32'(i), 1, 0, 0);
      cycle(1, 32'h3F, 1, 0, 0);
      n_pops = 0;
      for (int i = 0; i < 6; i++) cycle(0, 32'h0, 0, 0, 0);
      check_eq("full_drain_pops", 64'(n_pops), 64'd4);
      check_eq("full_drain_empty", 64'(fu_done), 64'd0);

      // Simultaneous push and pop at count 2.
      cycle(1, 32'h41, 1, 0, 0);
      cycle(1, 32'h42, 1, 0, 0);
      cycle(1, 32'h43, 0, 0, 0);
      check_eq("pushpop_count", 64'(count), 64'd2);
      check_eq("pushpop_head", 64'(wr_data.result), 64'h42);
      repeat (3) cycle(0, 32'h0, 0, 0, 0);

      // Wrap-around with interleaved stalls.
      n_pops = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1, 32'h60 + 32'(i), (i % 3) == 1, 0, 0);
         if (i % 2 == 0) cycle(0, 32'h0, 1, 0, 0);
      end
      repeat (6) cycle(0, 32'h0, 0, 0, 0);
      check_eq("wrap_pops", 64'(n_pops), 64'd6);

      // Flush with a same-cycle push at count 3.
      for (int i = 0; i < 3; i++) cycle(1, 32'h70 + 32'(i), 1, 0, 0);
      cycle(1, 32'hFF, 0, 1, 0);
      check_eq("flush_count", 64'(count), 64'd0);
      check_eq("flush_ready", 64'(in_ready), 64'd1);
      repeat (2) cycle(0, 32'h0, 0, 0, 0);

      // Mid-stream reset.
      cycle(1, 32'h81, 1, 0, 0);
      cycle(1, 32'h82, 1, 0, 0);
      cycle(1, 32'h83, 0, 0, 1);
      repeat (2) cycle(0, 32'h0, 0, 0, 0);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 200; i++) begin
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0,
               $urandom_range(0, 30) == 0, 0);
      end
      repeat (8) cycle(0, 32'h0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
